// File: rtl/ahb_uart_loader_pkg.sv
// Shared constants and types for the UART-to-AHB program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb_uart_loader_pkg;

  // AHB-Lite encodings used by the loader
  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // Frame start marker
  localparam logic [7:0] LOADER_HDR = 8'hA5;

  // Frame FSM states
  localparam logic [2:0] F_HDR  = 3'd0;
  localparam logic [2:0] F_LEN0 = 3'd1;
  localparam logic [2:0] F_LEN1 = 3'd2;
  localparam logic [2:0] F_DATA = 3'd3;
  localparam logic [2:0] F_CSUM = 3'd4;
  localparam logic [2:0] F_FIN  = 3'd5;

  // AHB master FSM states
  localparam logic [1:0] A_IDLE = 2'd0;
  localparam logic [1:0] A_ADDR = 2'd1;
  localparam logic [1:0] A_DATA = 2'd2;

  // UART receiver states
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  // One pending write: byte address plus word
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wbuf_t;

  // Byte address of word number idx relative to base
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/ahb_uart_loader_if.sv
// AHB-Lite write-master signal bundle between loader and slave mux.
// Latency: n/a (wires only).
// Backpressure: slave stretches either phase by holding HREADY low.
interface ahb_uart_loader_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HREADY
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HREADY
  );
endinterface

// File: rtl/ahb_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchroniser.
// Latency: rx_valid/rx_ferr pulse one cycle after the mid stop-bit sample.
// Backpressure: none; every byte is presented once and must be consumed.
module uart_rx_byte
  import ahb_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int             CW      = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // Synchroniser plus one delayed copy for falling-edge detection; idle line is high
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= RXD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Bit timing: confirm start at half a bit, then sample every full bit at mid-bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // a glitch that is high again at mid-start is not a start bit
          state_d = rxd_sync_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (rxd_sync_q) valid_d = 1'b1;
          else            ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/ahb_uart_loader.sv
// UART framed-image loader writing words into code memory as an AHB-Lite master.
// Latency: NONSEQ two cycles after the 4th byte of a word; 3+ cycles per write.
// Backpressure: HREADY stalls either phase; a word arriving while the buffer is full is an overrun error.
module ahb_uart_loader
  import ahb_uart_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 4096
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              RXD,
  ahb_uart_loader_if.master ahb,
  output logic              LOADING,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr;

  // frame FSM state
  logic [2:0]  fst_q, fst_d;
  logic [7:0]  nlo_q, nlo_d;
  logic [15:0] nwords_q, nwords_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] wsr_q, wsr_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        loading_q, loading_d;
  logic        buf_load;
  logic [31:0] word_full;
  logic [15:0] len_now;

  // write buffer and AHB FSM state
  logic        buf_full_q, buf_full_d;
  wbuf_t       buf_q, buf_d;
  logic [1:0]  ast_q, ast_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .RXD      (RXD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign word_full = {rx_data, wsr_q[31:8]};
  assign len_now   = {rx_data, nlo_q};

  // Frame parser: header, length, little-endian words, XOR checksum, then completion handshake
  always_comb begin
    fst_d     = fst_q;
    nlo_d     = nlo_q;
    nwords_d  = nwords_q;
    xor_d     = xor_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    wsr_d     = wsr_q;
    err_d     = err_q;
    done_d    = done_q;
    loading_d = loading_q;
    buf_load  = 1'b0;
    if (fst_q == F_FIN) begin
      // serial input is ignored once the image is accepted
      if (!done_q && ast_q == A_IDLE && !buf_full_q) begin
        done_d    = 1'b1;
        loading_d = 1'b0;
      end
    end else if (rx_ferr) begin
      err_d = 1'b1;
      fst_d = F_HDR;
    end else if (rx_valid) begin
      case (fst_q)
        F_HDR: begin
          if (rx_data == LOADER_HDR) begin
            err_d = 1'b0;
            xor_d = 8'h00;
            fst_d = F_LEN0;
          end
        end
        F_LEN0: begin
          nlo_d = rx_data;
          xor_d = xor_q ^ rx_data;
          fst_d = F_LEN1;
        end
        F_LEN1: begin
          xor_d    = xor_q ^ rx_data;
          nwords_d = len_now;
          widx_d   = '0;
          bidx_d   = '0;
          if ({1'b0, len_now} > MAX_W) begin
            err_d = 1'b1;
            fst_d = F_HDR;
          end else if (len_now == 16'd0) begin
            fst_d = F_CSUM;
          end else begin
            fst_d = F_DATA;
          end
        end
        F_DATA: begin
          xor_d  = xor_q ^ rx_data;
          wsr_d  = word_full;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if (buf_full_q) begin
              // previous word still in flight: drop this one and abort the frame
              err_d = 1'b1;
              fst_d = F_HDR;
            end else begin
              buf_load = 1'b1;
              widx_d   = widx_q + 16'd1;
              if (widx_q + 16'd1 == nwords_q) fst_d = F_CSUM;
            end
          end
        end
        F_CSUM: begin
          if (rx_data == xor_q) begin
            fst_d = F_FIN;
          end else begin
            err_d = 1'b1;
            fst_d = F_HDR;
          end
        end
        default: fst_d = F_HDR;
      endcase
    end
  end

  // Single-word buffer and two-phase AHB write sequencer
  always_comb begin
    ast_d      = ast_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    case (ast_q)
      A_IDLE: begin
        if (buf_full_q) begin
          ast_d    = A_ADDR;
          haddr_d  = buf_q.addr;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
        end
      end
      A_ADDR: begin
        if (ahb.HREADY) begin
          ast_d    = A_DATA;
          hwdata_d = buf_q.data;
          htrans_d = HTRANS_IDLE;
          hwrite_d = 1'b0;
        end
      end
      A_DATA: begin
        if (ahb.HREADY) begin
          ast_d      = A_IDLE;
          buf_full_d = 1'b0;
        end
      end
      default: ast_d = A_IDLE;
    endcase
    // load and free are mutually exclusive: load needs the buffer empty
    if (buf_load) begin
      buf_full_d = 1'b1;
      buf_d.addr = word_addr(BASE_ADDR, widx_q);
      buf_d.data = word_full;
    end
  end

  // Frame, buffer and bus registers; reset abandons any partial transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fst_q      <= F_HDR;
      nlo_q      <= '0;
      nwords_q   <= '0;
      xor_q      <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      wsr_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      loading_q  <= 1'b1;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      ast_q      <= A_IDLE;
      haddr_q    <= BASE_ADDR;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
    end else begin
      fst_q      <= fst_d;
      nlo_q      <= nlo_d;
      nwords_q   <= nwords_d;
      xor_q      <= xor_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      wsr_q      <= wsr_d;
      err_q      <= err_d;
      done_q     <= done_d;
      loading_q  <= loading_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      ast_q      <= ast_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
    end
  end

  assign ahb.HADDR  = haddr_q;
  assign ahb.HTRANS = htrans_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HSIZE  = HSIZE_WORD;
  assign ahb.HBURST = HBURST_SINGLE;
  assign ahb.HPROT  = HPROT_DATA_PRIV;
  assign ahb.HWDATA = hwdata_q;
  assign LOADING    = loading_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_ahb_uart_loader.sv
// Bench for ahb_uart_loader: serial frames in, AHB writes checked against a queue.
// Latency: n/a.
// Backpressure: optional 5-cycle HREADY stalls in both phases.
module tb_ahb_uart_loader;
  import ahb_uart_loader_pkg::*;

  localparam int CPB = 8;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic RXD;
  logic LOADING, DONE, ERR;

  ahb_uart_loader_if bus();

  ahb_uart_loader #(
    .CLKS_PER_BIT (CPB),
    .BASE_ADDR    (32'h0000_0000),
    .MAX_WORDS    (4096)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .RXD     (RXD),
    .ahb     (bus),
    .LOADING (LOADING),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  always #5 HCLK = ~HCLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  wbuf_t       sb_q[$];
  wbuf_t       mon_exp;
  logic [7:0]  fb[$];
  bit          stall_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave: HREADY generator ----------------
  bit neg_nonseq = 1'b0;
  bit slv_data   = 1'b0;
  int stall_left = 0;

  always @(negedge HCLK) neg_nonseq = (bus.HTRANS == HTRANS_NONSEQ);

  always @(posedge HCLK) begin
    bit rdy_was;
    rdy_was = bus.HREADY;
    #1;
    if (!HRESETn) begin
      slv_data   = 1'b0;
      stall_left = 0;
      bus.HREADY = 1'b1;
    end else begin
      if (rdy_was) slv_data = neg_nonseq;
      if (rdy_was && stall_en && (bus.HTRANS == HTRANS_NONSEQ || slv_data)) stall_left = 5;
      if (stall_left > 0) begin
        bus.HREADY = 1'b0;
        stall_left--;
      end else begin
        bus.HREADY = 1'b1;
      end
    end
  end

  // ---------------- monitor: pops scoreboard on each completed write ----------------
  bit          m_data = 1'b0, hold_a = 1'b0, hold_d = 1'b0;
  logic [31:0] m_addr, held_a, held_d;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      m_data = 1'b0;
      hold_a = 1'b0;
      hold_d = 1'b0;
    end else begin
      if (m_data) begin
        if (hold_d) check("hwdata_stable", bus.HWDATA, held_d);
        held_d = bus.HWDATA;
        if (bus.HREADY) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", m_addr, bus.HWDATA);
          end else begin
            mon_exp = sb_q.pop_front();
            check("write_addr", m_addr, mon_exp.addr);
            check("write_data", bus.HWDATA, mon_exp.data);
          end
          m_data = 1'b0;
          hold_d = 1'b0;
        end else begin
          hold_d = 1'b1;
        end
      end
      if (bus.HTRANS == HTRANS_NONSEQ) begin
        if (hold_a) check("haddr_stable", bus.HADDR, held_a);
        held_a = bus.HADDR;
        if (bus.HREADY) begin
          check("hwrite_nonseq", {31'b0, bus.HWRITE}, 32'd1);
          m_addr = bus.HADDR;
          m_data = 1'b1;
          hold_a = 1'b0;
        end else begin
          hold_a = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bit_time(input logic v);
    RXD = v;
    repeat (CPB) @(negedge HCLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
    bit_time(1'b1);
  endtask

  task automatic send_fb();
    foreach (fb[i]) send_byte(fb[i], 1'b1);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wbuf_t w;
    w.addr = a;
    w.data = d;
    sb_q.push_back(w);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"},  {30'b0, bus.HTRANS}, 32'd0);
    check({tag, "_haddr"},   bus.HADDR, 32'h0000_0000);
    check({tag, "_hwrite"},  {31'b0, bus.HWRITE}, 32'd0);
    check({tag, "_hwdata"},  bus.HWDATA, 32'd0);
    check({tag, "_loading"}, {31'b0, LOADING}, 32'd1);
    check({tag, "_done"},    {31'b0, DONE}, 32'd0);
    check({tag, "_err"},     {31'b0, ERR}, 32'd0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !DONE; i++) @(negedge HCLK);
  endtask

  task automatic check_loaded(input string tag);
    wait_done(200);
    repeat (2) @(negedge HCLK);
    check({tag, "_done"},    {31'b0, DONE}, 32'd1);
    check({tag, "_loading"}, {31'b0, LOADING}, 32'd0);
    check({tag, "_err"},     {31'b0, ERR}, 32'd0);
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
  endtask

  task automatic frame_two_words();
    // checksum covers the count bytes: 02^00^11^22^33^44^55^66^77^88 = 8A
    push(32'h0000_0000, 32'h4433_2211);
    push(32'h0000_0004, 32'h8877_6655);
    fb = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
    send_fb();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RXD     = 1'b1;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check_reset_outputs("rst");
    check("rst_hsize",  {29'b0, bus.HSIZE}, 32'd2);
    check("rst_hburst", {29'b0, bus.HBURST}, 32'd0);
    check("rst_hprot",  {28'b0, bus.HPROT}, 32'd3);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // two-word image, zero-wait slave
    frame_two_words();
    check_loaded("f1");

    // same image with stalled address and data phases
    do_reset();
    stall_en = 1'b1;
    frame_two_words();
    check_loaded("stall");
    stall_en = 1'b0;

    // bad checksum: word already written stays, then a correct resend
    do_reset();
    push(32'h0000_0000, 32'hEFBE_ADDE);
    fb = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_fb();
    repeat (20) @(negedge HCLK);
    check("badcs_err",      {31'b0, ERR}, 32'd1);
    check("badcs_loading",  {31'b0, LOADING}, 32'd1);
    check("badcs_done",     {31'b0, DONE}, 32'd0);
    check("badcs_sb_empty", sb_q.size(), 32'd0);
    fb = '{8'hA5};
    send_fb();
    check("resend_err_clear", {31'b0, ERR}, 32'd0);
    // 01^00^DE^AD^BE^EF = 23
    push(32'h0000_0000, 32'hEFBE_ADDE);
    fb = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send_fb();
    check_loaded("resend");

    // count 4097 exceeds the memory: error, no bus traffic, data ignored
    do_reset();
    fb = '{8'hA5, 8'h01, 8'h10};
    send_fb();
    check("toolong_err", {31'b0, ERR}, 32'd1);
    fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_fb();
    repeat (20) @(negedge HCLK);
    check("toolong_err_sticky", {31'b0, ERR}, 32'd1);
    check("toolong_loading",    {31'b0, LOADING}, 32'd1);
    check("toolong_htrans",     {30'b0, bus.HTRANS}, 32'd0);

    // framing error mid-word: back to header, trailing bytes ignored
    fb = '{8'hA5, 8'h01, 8'h00, 8'hDE};
    send_fb();
    check("ferr_hdr_clears", {31'b0, ERR}, 32'd0);
    send_byte(8'hAD, 1'b0);
    check("ferr_err", {31'b0, ERR}, 32'd1);
    fb = '{8'hBE, 8'hEF, 8'h23};
    send_fb();
    repeat (20) @(negedge HCLK);
    check("ferr_done",     {31'b0, DONE}, 32'd0);
    check("ferr_err_held", {31'b0, ERR}, 32'd1);

    // reset in the middle of a frame, then a clean load
    do_reset();
    fb = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_fb();
    HRESETn = 1'b0;
    @(negedge HCLK);
    check_reset_outputs("midrst");
    HRESETn = 1'b1;
    @(negedge HCLK);
    frame_two_words();
    check_loaded("after_rst");

    // empty image
    do_reset();
    fb = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_fb();
    check_loaded("empty");

    repeat (10) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
